// File: rtl/pipe_stage_elastic.sv
// ---------------------------------------------------------------------------
// pipe_stage_elastic
//
// Purpose:
//   Inter-stage pipeline register (EX/MEM, MEM/WB and later stages) using a
//   valid/ready handshake instead of a bare write-enable. Entries are held in
//   a two-entry skid buffer. Because of the skid entry, in_ready depends only
//   on registered state and flush, so downstream back-pressure never has a
//   combinational path to the upstream stage. Control bits are gated to zero
//   whenever the stage holds no valid entry. Data bits are not gated. A
//   saturating counter records stall cycles for performance debug.
//
// Parameters:
//   CTRL_W    width of the control bundle (MemWrite, MemRead, RegWrite, ...)
//   DATA_W    width of the data bundle (ALU value, store data, dest reg, ...)
//   CNT_W     width of the stall counter
//
// Ports:
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   in_valid   in   upstream entry valid
//   in_ready   out  stage can accept (state and flush only)
//   in_ctrl    in   upstream control bits
//   in_data    in   upstream data bits
//   out_valid  out  head entry valid
//   out_ready  in   downstream accepts the head entry
//   out_ctrl   out  head control bits, all-zero when out_valid=0
//   out_data   out  head data bits, shown even when out_valid=0
//   flush      in   synchronous kill of all held and incoming entries
//   stall_cnt  out  saturating count of cycles with out_valid && !out_ready
// ---------------------------------------------------------------------------
module pipe_stage_elastic #(
   parameter int CTRL_W = 4,
   parameter int DATA_W = 36,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [CTRL_W-1:0] in_ctrl,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [CTRL_W-1:0] out_ctrl,
   output logic [DATA_W-1:0] out_data,
   input  logic              flush,
   output logic [CNT_W-1:0]  stall_cnt
);

   // The state encodes both valid bits. The main entry is valid in ONE and
   // FULL. The skid entry is valid only in FULL.
   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } stageState_t;

   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   stageState_t       state;
   stageState_t       nextState;

   logic [CTRL_W-1:0] mainCtrl;
   logic [DATA_W-1:0] mainData;
   logic [CTRL_W-1:0] skidCtrl;
   logic [DATA_W-1:0] skidData;

   logic              mainValid;
   logic              accept;
   logic              pop;
   logic              loadMainFromIn;
   logic              loadMainFromSkid;
   logic              loadSkid;
   logic [CNT_W-1:0]  stallCount;

   // The handshake terms are derived here.
   // in_ready is gated with rst_n so it reads 0 while reset is held. It
   // becomes 1 on the first cycle after release without waiting for an edge.
   // Flush blocks acceptance so an incoming entry cannot escape the kill.
   assign mainValid = (state != EMPTY);
   assign in_ready  = rst_n && (state != FULL) && !flush;
   assign out_valid = mainValid;
   assign accept    = in_valid && in_ready;
   assign pop       = mainValid && out_ready;

   // Only the control bundle is gated on bubbles. This prevents a stale
   // RegWrite or MemWrite from acting downstream. Data passes through
   // untouched because nothing consumes it without a valid control bit.
   assign out_ctrl  = mainCtrl & {CTRL_W{mainValid}};
   assign out_data  = mainData;
   assign stall_cnt = stallCount;

   // The state register resets asynchronously so the outputs clear
   // immediately, even in the middle of a transfer.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= EMPTY;
      end else begin
         state <= nextState;
      end
   end

   // Next-state and load-select logic.
   // Flush overrides every other event and empties the stage. A pop in the
   // same cycle still completes downstream, because out_valid was already
   // presented for that cycle. When the stage is ONE and both accept and pop
   // occur, the new entry goes straight into main. This keeps throughput at
   // one entry per cycle without using the skid entry.
   always_comb begin
      nextState        = state;
      loadMainFromIn   = 1'b0;
      loadMainFromSkid = 1'b0;
      loadSkid         = 1'b0;
      if (flush) begin
         nextState = EMPTY;
      end else begin
         case (state)
            EMPTY: begin
               if (accept) begin
                  nextState      = ONE;
                  loadMainFromIn = 1'b1;
               end
            end
            ONE: begin
               if (accept && pop) begin
                  loadMainFromIn = 1'b1;
               end else if (accept) begin
                  nextState = FULL;
                  loadSkid  = 1'b1;
               end else if (pop) begin
                  nextState = EMPTY;
               end
            end
            FULL: begin
               if (pop) begin
                  nextState        = ONE;
                  loadMainFromSkid = 1'b1;
               end
            end
            default: begin
               nextState = EMPTY;
            end
         endcase
      end
   end

   // Main (head) register.
   // It loads either the incoming entry or the older skid entry. Its contents
   // are kept across flushes, so only the valid bits change on a kill.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mainCtrl <= '0;
         mainData <= '0;
      end else if (loadMainFromSkid) begin
         mainCtrl <= skidCtrl;
         mainData <= skidData;
      end else if (loadMainFromIn) begin
         mainCtrl <= in_ctrl;
         mainData <= in_data;
      end
   end

   // Skid register.
   // It catches the one entry accepted in the cycle that downstream stalls.
   // This is what lets in_ready stay registered.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         skidCtrl <= '0;
         skidData <= '0;
      end else if (loadSkid) begin
         skidCtrl <= in_ctrl;
         skidData <= in_data;
      end
   end

   // Stall counter.
   // It counts every cycle where the head is offered but refused, and it
   // sticks at all-ones. Flush does not clear it, so the count covers the
   // whole run since reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stallCount <= '0;
      end else if (mainValid && !out_ready && (stallCount != CNT_MAX)) begin
         stallCount <= stallCount + CNT_ONE;
      end
   end

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// ---------------------------------------------------------------------------
// tb_pipe_stage_elastic
//
// Purpose:
//   Self-checking bench for pipe_stage_elastic. Expected entries go into a
//   queue when the bench drives an entry it expects the stage to accept.
//   They are popped and compared when the stage presents a valid head while
//   out_ready is high. A second instance with a 3-bit stall counter covers
//   saturation.
//
// Timing: inputs change and outputs are sampled at the falling edge, and
//   in_ready is re-sampled 1 ns after inputs change.
// ---------------------------------------------------------------------------
module tb_pipe_stage_elastic;

   localparam int CTRL_W    = 4;
   localparam int DATA_W    = 36;
   localparam int CNT_W     = 16;
   localparam int SAT_CNT_W = 3;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              in_valid;
   logic              in_ready;
   logic [CTRL_W-1:0] in_ctrl;
   logic [DATA_W-1:0] in_data;
   logic              out_valid;
   logic              out_ready;
   logic [CTRL_W-1:0] out_ctrl;
   logic [DATA_W-1:0] out_data;
   logic              flush;
   logic [CNT_W-1:0]  stall_cnt;

   logic                 satInValid;
   logic                 satInReady;
   logic [CTRL_W-1:0]    satInCtrl;
   logic [DATA_W-1:0]    satInData;
   logic                 satOutValid;
   logic                 satOutReady;
   logic [CTRL_W-1:0]    satOutCtrl;
   logic [DATA_W-1:0]    satOutData;
   logic                 satFlush;
   logic [SAT_CNT_W-1:0] satStallCnt;

   int checkCount = 0;
   int passCount  = 0;
   logic [CTRL_W+DATA_W-1:0] expQ[$];
   logic [CTRL_W+DATA_W-1:0] expEntry;

   always #5 clk = ~clk;

   pipe_stage_elastic #(.CTRL_W(CTRL_W), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_ctrl   (in_ctrl),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_ctrl  (out_ctrl),
      .out_data  (out_data),
      .flush     (flush),
      .stall_cnt (stall_cnt)
   );

   pipe_stage_elastic #(.CTRL_W(CTRL_W), .DATA_W(DATA_W), .CNT_W(SAT_CNT_W)) satDut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (satInValid),
      .in_ready  (satInReady),
      .in_ctrl   (satInCtrl),
      .in_data   (satInData),
      .out_valid (satOutValid),
      .out_ready (satOutReady),
      .out_ctrl  (satOutCtrl),
      .out_data  (satOutData),
      .flush     (satFlush),
      .stall_cnt (satStallCnt)
   );

   // While reset is held, every output must already be zero.
   // in_ready must rise on the first cycle with rst_n released.
   task automatic test_reset();
      #1;
      checkCount++;
      if (out_valid !== 1'b0) $display("[TB] FAIL reset_out_valid: got %b expected 0", out_valid);
      else passCount++;
      checkCount++;
      if (out_ctrl !== '0) $display("[TB] FAIL reset_out_ctrl: got %h expected 0", out_ctrl);
      else passCount++;
      checkCount++;
      if (out_data !== '0) $display("[TB] FAIL reset_out_data: got %h expected 0", out_data);
      else passCount++;
      checkCount++;
      if (in_ready !== 1'b0) $display("[TB] FAIL reset_in_ready: got %b expected 0", in_ready);
      else passCount++;
      checkCount++;
      if (stall_cnt !== '0) $display("[TB] FAIL reset_stall_cnt: got %0d expected 0", stall_cnt);
      else passCount++;
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      checkCount++;
      if (in_ready !== 1'b1) $display("[TB] FAIL reset_release_ready: got %b expected 1", in_ready);
      else passCount++;
   endtask

   // Ten back-to-back entries with out_ready high.
   // Each entry should come out one cycle later, in order, with no gaps.
   task automatic test_stream();
      out_ready = 1'b1;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (i >= 1 && i <= 10) begin
            checkCount++;
            if (out_valid !== 1'b1) $display("[TB] FAIL stream_gap[%0d]: out_valid got %b expected 1", i, out_valid);
            else passCount++;
         end
         if (out_valid === 1'b1 && out_ready === 1'b1) begin
            checkCount++;
            if (expQ.size() == 0) begin
               $display("[TB] FAIL stream_extra: got %h expected no entry", {out_ctrl, out_data});
            end else begin
               expEntry = expQ.pop_front();
               if ({out_ctrl, out_data} !== expEntry) $display("[TB] FAIL stream_entry[%0d]: got %h expected %h", i, {out_ctrl, out_data}, expEntry);
               else passCount++;
            end
         end
         if (i < 10) begin
            in_valid = 1'b1;
            in_ctrl  = 4'b1010;
            in_data  = DATA_W'(i);
            expQ.push_back({4'b1010, DATA_W'(i)});
            #1;
            checkCount++;
            if (in_ready !== 1'b1) $display("[TB] FAIL stream_ready[%0d]: got %b expected 1", i, in_ready);
            else passCount++;
         end else begin
            in_valid = 1'b0;
         end
      end
      checkCount++;
      if (out_valid !== 1'b0) $display("[TB] FAIL stream_drained: out_valid got %b expected 0", out_valid);
      else passCount++;
      checkCount++;
      if (expQ.size() != 0) $display("[TB] FAIL stream_missing: got %0d entries left expected 0", expQ.size());
      else passCount++;
      checkCount++;
      if (stall_cnt !== '0) $display("[TB] FAIL stream_stall_cnt: got %0d expected 0", stall_cnt);
      else passCount++;
   endtask

   // Fill the stage with 0x11 and 0x22 while downstream stalls, hold for
   // five more cycles, then release. One stall is counted during the fill,
   // because 0x11 is offered while 0x22 arrives. That gives a total of 6.
   task automatic test_back_pressure();
      @(negedge clk);
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_ctrl   = 4'b1010;
      in_data   = 36'h11;
      expQ.push_back({4'b1010, 36'h11});
      @(negedge clk);
      checkCount++;
      if (out_data !== 36'h11) $display("[TB] FAIL bp_first_head: got %h expected 11", out_data);
      else passCount++;
      in_data = 36'h22;
      expQ.push_back({4'b1010, 36'h22});
      #1;
      checkCount++;
      if (in_ready !== 1'b1) $display("[TB] FAIL bp_ready_one: got %b expected 1", in_ready);
      else passCount++;
      @(negedge clk);
      in_valid = 1'b0;
      checkCount++;
      if (in_ready !== 1'b0) $display("[TB] FAIL bp_ready_full: got %b expected 0", in_ready);
      else passCount++;
      checkCount++;
      if (stall_cnt !== 16'd1) $display("[TB] FAIL bp_stall_fill: got %0d expected 1", stall_cnt);
      else passCount++;
      for (int k = 1; k <= 5; k++) begin
         @(negedge clk);
         checkCount++;
         if (out_data !== 36'h11 || in_ready !== 1'b0) $display("[TB] FAIL bp_hold[%0d]: got data %h ready %b expected data 11 ready 0", k, out_data, in_ready);
         else passCount++;
         checkCount++;
         if (stall_cnt !== CNT_W'(1 + k)) $display("[TB] FAIL bp_stall[%0d]: got %0d expected %0d", k, stall_cnt, 1 + k);
         else passCount++;
      end
      out_ready = 1'b1;
      for (int k = 0; k < 2; k++) begin
         if (k == 1) begin
            checkCount++;
            if (in_ready !== 1'b1) $display("[TB] FAIL bp_ready_after_pop: got %b expected 1", in_ready);
            else passCount++;
         end
         checkCount++;
         if (out_valid !== 1'b1 || expQ.size() == 0) begin
            $display("[TB] FAIL bp_drain[%0d]: got valid %b expected valid 1 with entry pending", k, out_valid);
         end else begin
            expEntry = expQ.pop_front();
            if ({out_ctrl, out_data} !== expEntry) $display("[TB] FAIL bp_drain[%0d]: got %h expected %h", k, {out_ctrl, out_data}, expEntry);
            else passCount++;
         end
         @(negedge clk);
      end
      checkCount++;
      if (out_valid !== 1'b0 || stall_cnt !== 16'd6) $display("[TB] FAIL bp_end: got valid %b stall %0d expected valid 0 stall 6", out_valid, stall_cnt);
      else passCount++;
   endtask

   // Flush while FULL with a new entry on the input.
   // Everything should vanish and 0x33 must never reach the output. The data
   // register should keep 0x55, and the stall count should survive the flush.
   task automatic test_flush_full();
      @(negedge clk);
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_ctrl   = 4'b0110;
      in_data   = 36'h55;
      @(negedge clk);
      in_data = 36'h66;
      @(negedge clk);
      checkCount++;
      if (in_ready !== 1'b0) $display("[TB] FAIL flush_pre_full: got %b expected 0", in_ready);
      else passCount++;
      flush   = 1'b1;
      in_data = 36'h33;
      #1;
      checkCount++;
      if (in_ready !== 1'b0) $display("[TB] FAIL flush_ready: got %b expected 0", in_ready);
      else passCount++;
      @(negedge clk);
      flush     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      checkCount++;
      if (out_valid !== 1'b0 || out_ctrl !== '0) $display("[TB] FAIL flush_cleared: got valid %b ctrl %h expected 0 0", out_valid, out_ctrl);
      else passCount++;
      checkCount++;
      if (out_data !== 36'h55) $display("[TB] FAIL flush_data_kept: got %h expected 55", out_data);
      else passCount++;
      checkCount++;
      if (stall_cnt !== 16'd8) $display("[TB] FAIL flush_stall_kept: got %0d expected 8", stall_cnt);
      else passCount++;
      #1;
      checkCount++;
      if (in_ready !== 1'b1) $display("[TB] FAIL flush_ready_after: got %b expected 1", in_ready);
      else passCount++;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         checkCount++;
         if (out_valid !== 1'b0) $display("[TB] FAIL flush_leak[%0d]: got valid %b data %h expected valid 0", k, out_valid, out_data);
         else passCount++;
      end
   endtask

   // After an entry leaves, the control bits must read zero, while out_data
   // still shows the last entry.
   task automatic test_bubble_gating();
      @(negedge clk);
      out_ready = 1'b1;
      in_valid  = 1'b1;
      in_ctrl   = 4'b1111;
      in_data   = 36'h99;
      expQ.push_back({4'b1111, 36'h99});
      @(negedge clk);
      in_valid = 1'b0;
      checkCount++;
      if (out_valid !== 1'b1 || expQ.size() == 0) begin
         $display("[TB] FAIL bubble_entry: got valid %b expected 1", out_valid);
      end else begin
         expEntry = expQ.pop_front();
         if ({out_ctrl, out_data} !== expEntry) $display("[TB] FAIL bubble_entry: got %h expected %h", {out_ctrl, out_data}, expEntry);
         else passCount++;
      end
      @(negedge clk);
      checkCount++;
      if (out_ctrl !== 4'b0000) $display("[TB] FAIL bubble_ctrl: got %b expected 0000", out_ctrl);
      else passCount++;
      checkCount++;
      if (out_data !== 36'h99) $display("[TB] FAIL bubble_data: got %h expected 99", out_data);
      else passCount++;
   endtask

   // Drop rst_n between edges while the stage is FULL.
   // The outputs must clear before any clock edge. After release, a new
   // entry must flow through normally.
   task automatic test_async_reset();
      @(negedge clk);
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_ctrl   = 4'b0011;
      in_data   = 36'hAA;
      @(negedge clk);
      in_data = 36'hBB;
      @(negedge clk);
      in_valid = 1'b0;
      checkCount++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1) $display("[TB] FAIL arst_pre_full: got ready %b valid %b expected 0 1", in_ready, out_valid);
      else passCount++;
      #2;
      rst_n = 1'b0;
      #1;
      checkCount++;
      if (out_valid !== 1'b0 || out_ctrl !== '0 || out_data !== '0) $display("[TB] FAIL arst_outputs: got valid %b ctrl %h data %h expected 0 0 0", out_valid, out_ctrl, out_data);
      else passCount++;
      checkCount++;
      if (in_ready !== 1'b0 || stall_cnt !== '0) $display("[TB] FAIL arst_ready_cnt: got ready %b stall %0d expected 0 0", in_ready, stall_cnt);
      else passCount++;
      expQ.delete();
      @(negedge clk);
      rst_n     = 1'b1;
      out_ready = 1'b1;
      in_valid  = 1'b1;
      in_ctrl   = 4'b0101;
      in_data   = 36'h44;
      expQ.push_back({4'b0101, 36'h44});
      #1;
      checkCount++;
      if (in_ready !== 1'b1) $display("[TB] FAIL arst_release_ready: got %b expected 1", in_ready);
      else passCount++;
      @(negedge clk);
      in_valid = 1'b0;
      checkCount++;
      if (out_valid !== 1'b1 || expQ.size() == 0) begin
         $display("[TB] FAIL arst_entry: got valid %b expected 1", out_valid);
      end else begin
         expEntry = expQ.pop_front();
         if ({out_ctrl, out_data} !== expEntry) $display("[TB] FAIL arst_entry: got %h expected %h", {out_ctrl, out_data}, expEntry);
         else passCount++;
      end
      @(negedge clk);
      checkCount++;
      if (out_valid !== 1'b0) $display("[TB] FAIL arst_drained: got valid %b expected 0", out_valid);
      else passCount++;
   endtask

   // On the 3-bit counter build, hold one entry against a stalled downstream.
   // The counter should climb to 7 and stay there.
   task automatic test_saturation();
      @(negedge clk);
      satOutReady = 1'b0;
      satInValid  = 1'b1;
      satInCtrl   = 4'b0001;
      satInData   = 36'h5;
      @(negedge clk);
      satInValid = 1'b0;
      checkCount++;
      if (satOutValid !== 1'b1 || satStallCnt !== 3'd0) $display("[TB] FAIL sat_start: got valid %b cnt %0d expected 1 0", satOutValid, satStallCnt);
      else passCount++;
      for (int k = 1; k <= 12; k++) begin
         @(negedge clk);
         checkCount++;
         if (satStallCnt !== SAT_CNT_W'((k > 7) ? 7 : k)) $display("[TB] FAIL sat_cnt[%0d]: got %0d expected %0d", k, satStallCnt, (k > 7) ? 7 : k);
         else passCount++;
      end
   endtask

   // The tests run in order on the same stage, and each one starts from the
   // state the previous one left behind.
   initial begin
      rst_n       = 1'b0;
      in_valid    = 1'b0;
      in_ctrl     = '0;
      in_data     = '0;
      out_ready   = 1'b0;
      flush       = 1'b0;
      satInValid  = 1'b0;
      satInCtrl   = '0;
      satInData   = '0;
      satOutReady = 1'b0;
      satFlush    = 1'b0;
      test_reset();
      test_stream();
      test_back_pressure();
      test_flush_full();
      test_bubble_gating();
      test_async_reset();
      test_saturation();
      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
